// File: rtl/step_ctrl_pkg.sv
// Shared types for the up/down step controller: FSM state encoding and the
// direction constants driven onto Up.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        HOLD = 2'b10,
        LOCK = 2'b11
    } step_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-flop synchroniser followed by a
// saturating debounce counter. Level is the accepted (debounced) button
// state; Rise is a one-cycle pulse on the edge Level goes 0 -> 1.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Raw,
    output logic Level,
    output logic Rise
);

    localparam int              CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   C_MAX  = CW'(DEBOUNCE_CYCLES);

    logic          r_s1;
    logic          r_s2;
    logic          r_lvl;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // Two-stage synchroniser for the asynchronous raw button
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= Raw;
            r_s2 <= r_s1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching edges
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_lvl  <= 1'b0;
            r_rise <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_rise <= 1'b0;
            if (r_s2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                // this edge is the last one of the required mismatch run
                r_lvl  <= r_s2;
                r_rise <= r_s2;
                r_cnt  <= '0;
            end else if (r_cnt != C_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign Level = r_lvl;
    assign Rise  = r_rise;

endmodule

// File: rtl/updown_step_ctrl.sv
// Up/down step controller: converts two raw push-buttons into a one-cycle
// En strobe plus a held Up direction for the downstream 3-bit counter.
// Pressing both buttons together locks the controller until both are released.
// Optional feature macro: STEP_AUTOREPEAT_EN (auto-repeat steps while held).
module updown_step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BtnUp,
    input  logic BtnDn,
    output logic En,
    output logic Up,
    output logic Locked
);

    logic        w_lvl_up;
    logic        w_rise_up;
    logic        w_lvl_dn;
    logic        w_rise_dn;
    logic        w_both;
    logic        w_active_lvl;
    logic        w_rep_due;

    step_state_t r_state;
    logic        r_en;
    logic        r_up;
    logic        r_locked;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .Clk   (Clk),
        .Reset (Reset),
        .Raw   (BtnUp),
        .Level (w_lvl_up),
        .Rise  (w_rise_up)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .Clk   (Clk),
        .Reset (Reset),
        .Raw   (BtnDn),
        .Level (w_lvl_dn),
        .Rise  (w_rise_dn)
    );

    assign w_both       = w_lvl_up & w_lvl_dn;
    // the held button is the one whose direction was latched at the last step
    assign w_active_lvl = (r_up == DIR_UP) ? w_lvl_up : w_lvl_dn;

`ifdef STEP_AUTOREPEAT_EN
    localparam int            RMAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW        = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RC_DELAY  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RC_PERIOD = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rcnt;
    logic          r_rep;

    // first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
    assign w_rep_due = (r_state == HOLD) && (r_rcnt == (r_rep ? RC_PERIOD : RC_DELAY));

    // Repeat timer: counts HOLD cycles, reloads on each repeat step, clears outside HOLD
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rcnt <= '0;
            r_rep  <= 1'b0;
        end else if (r_state == HOLD && !w_both && w_active_lvl) begin
            if (w_rep_due) begin
                r_rcnt <= '0;
                r_rep  <= 1'b1;
            end else begin
                r_rcnt <= r_rcnt + 1'b1;
            end
        end else if (r_state == STEP) begin
            r_rcnt <= '0;
        end else begin
            r_rcnt <= '0;
            r_rep  <= 1'b0;
        end
    end
`else
    assign w_rep_due = 1'b0;

    // repeat timing is only consumed by the auto-repeat build; a zero value
    // would still be a configuration error, so it is referenced here too
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_invalid
    end
`endif

    // Step FSM with registered En/Up/Locked outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_en     <= 1'b0;
            r_up     <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_both) begin
                        r_state  <= LOCK;
                        r_locked <= 1'b1;
                    end else if (w_rise_up) begin
                        r_state <= STEP;
                        r_up    <= DIR_UP;
                        r_en    <= 1'b1;
                    end else if (w_rise_dn) begin
                        r_state <= STEP;
                        r_up    <= DIR_DN;
                        r_en    <= 1'b1;
                    end
                end
                STEP: begin
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (w_both) begin
                        r_state  <= LOCK;
                        r_locked <= 1'b1;
                    end else if (!w_active_lvl) begin
                        r_state <= IDLE;
                    end else if (w_rep_due) begin
                        r_state <= STEP;
                        r_en    <= 1'b1;
                    end
                end
                LOCK: begin
                    if (!w_lvl_up && !w_lvl_dn) begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign En     = r_en;
    assign Up     = r_up;
    assign Locked = r_locked;

endmodule

// File: tb/tb_updown_step_ctrl.sv
// Self-checking bench for updown_step_ctrl: directed scenarios followed by
// randomized button activity, all checked every cycle against a behavioural
// model built from the button/press/lock rules.
module tb_updown_step_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic Clk    = 1'b0;
    logic Reset  = 1'b1;
    logic BtnUp  = 1'b0;
    logic BtnDn  = 1'b0;
    logic En;
    logic Up;
    logic Locked;

    always #5 Clk = ~Clk;

    updown_step_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .BtnUp  (BtnUp),
        .BtnDn  (BtnDn),
        .En     (En),
        .Up     (Up),
        .Locked (Locked)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // raw samples seen 1 and 2 edges ago (synchroniser delay)
    bit m_raw1 [2];
    bit m_raw2 [2];
    // sliding window of the last DB synchronised samples
    bit m_win  [2][DB];
    int m_wn   [2];
    bit m_lvl  [2];
    bit m_rise [2];
    bit m_lock;
    bit m_stepnow;
    bit m_up;
    int m_active;   // -1 none, 0 up button, 1 down button
    int m_cyc;
    int m_nextrep;
    bit exp_en;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_raw1[b] = 0; m_raw2[b] = 0; m_wn[b] = 0;
            m_lvl[b]  = 0; m_rise[b] = 0;
            for (int i = 0; i < DB; i++) m_win[b][i] = 0;
        end
        m_lock = 0; m_stepnow = 0; m_up = 0; m_active = -1;
        m_cyc = 0; m_nextrep = 0; exp_en = 0;
    endtask

    task automatic model_edge(input bit rup, input bit rdn);
        bit en_new;
        bit raw [2];
        bit syn;
        bit all_mis;
        en_new = 0;
        raw[0] = rup;
        raw[1] = rdn;
        m_cyc++;
        // press / lock decisions use the debounced view from before this edge
        if (m_stepnow) begin
            // the step cycle always hands over to holding
        end else if (m_lock) begin
            if (!m_lvl[0] && !m_lvl[1]) m_lock = 0;
        end else if (m_lvl[0] && m_lvl[1]) begin
            m_lock = 1;
            m_active = -1;
        end else if (m_active >= 0) begin
            if (!m_lvl[m_active]) m_active = -1;
`ifdef STEP_AUTOREPEAT_EN
            else if (m_cyc == m_nextrep) begin
                en_new = 1;
                m_nextrep = m_cyc + RP + 1;
            end
`endif
        end else if (m_rise[0]) begin
            m_active = 0; m_up = 1; en_new = 1; m_nextrep = m_cyc + RD + 1;
        end else if (m_rise[1]) begin
            m_active = 1; m_up = 0; en_new = 1; m_nextrep = m_cyc + RD + 1;
        end
        m_stepnow = en_new;
        exp_en    = en_new;
        // debounced levels: flip once DB consecutive samples disagree
        for (int b = 0; b < 2; b++) begin
            syn = m_raw2[b];
            for (int i = DB - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
            m_win[b][0] = syn;
            if (m_wn[b] < DB) m_wn[b]++;
            m_rise[b] = 0;
            all_mis = (m_wn[b] == DB);
            for (int i = 0; i < DB; i++) if (m_win[b][i] == m_lvl[b]) all_mis = 0;
            if (all_mis) begin
                m_lvl[b]  = !m_lvl[b];
                m_rise[b] = m_lvl[b];
            end
            m_raw2[b] = m_raw1[b];
            m_raw1[b] = raw[b];
        end
    endtask

    // one clock: model and DUT advance, outputs compared 1 ns after the edge,
    // returns at the following falling edge where inputs may change
    task automatic tick();
        @(posedge Clk);
        if (Reset) model_reset();
        else model_edge(BtnUp, BtnDn);
        #1;
        chk("en", {31'd0, En}, {31'd0, exp_en});
        chk("up", {31'd0, Up}, {31'd0, m_up});
        chk("locked", {31'd0, Locked}, {31'd0, m_lock});
        @(negedge Clk);
    endtask

    // run n cycles, counting En pulses and the index of the first one
    task automatic run(input int n, output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (En === 1'b1) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
    endtask

    int cnt;
    int first;
    int seg;
    int len;

    initial begin
        model_reset();
        // test 1: reset then idle
        @(negedge Clk);
        tick();
        Reset = 1'b0;
        run(10, cnt, first);
        chk("t1_en_count", cnt, 0);
        chk("t1_locked", {31'd0, Locked}, 0);

        // test 2: single up press, 7-edge latency, one step per press
        BtnUp = 1'b1;
        run(20, cnt, first);
        chk("t2_latency", first, 7);
`ifndef STEP_AUTOREPEAT_EN
        chk("t2_en_count", cnt, 1);
`endif
        chk("t2_up", {31'd0, Up}, 1);
        BtnUp = 1'b0;
        run(12, cnt, first);

        // test 3: short glitch on down button is ignored
        BtnDn = 1'b1;
        run(3, cnt, first);
        BtnDn = 1'b0;
        run(15, cnt, first);
        chk("t3_en_count", cnt, 0);
        chk("t3_up", {31'd0, Up}, 1);

        // test 4: simultaneous press locks; only full release unlocks
        BtnUp = 1'b1; BtnDn = 1'b1;
        run(12, cnt, first);
        chk("t4_en_count", cnt, 0);
        chk("t4_locked", {31'd0, Locked}, 1);
        BtnUp = 1'b0;
        run(12, cnt, first);
        chk("t4_still_locked", {31'd0, Locked}, 1);
        BtnDn = 1'b0;
        run(12, cnt, first);
        chk("t4_unlocked", {31'd0, Locked}, 0);
        chk("t4_release_en", cnt, 0);

        // test 5: reset during a press, fresh latency after release
        BtnUp = 1'b1;
        run(2, cnt, first);
        Reset = 1'b1;
        run(2, cnt, first);
        chk("t5_reset_en", cnt, 0);
        Reset = 1'b0;
        run(15, cnt, first);
        chk("t5_latency", first, 7);
        chk("t5_en_count", cnt, 1);
        BtnUp = 1'b0;
        run(12, cnt, first);

`ifdef STEP_AUTOREPEAT_EN
        // test 6: held down button auto-repeats at +21 then every 9 cycles
        begin
            int idx [$];
            BtnDn = 1'b1;
            for (int i = 1; i <= 40; i++) begin
                tick();
                if (En === 1'b1) idx.push_back(i);
            end
            chk("t6_pulses", idx.size(), 3);
            if (idx.size() == 3) begin
                chk("t6_first", idx[0], 7);
                chk("t6_gap1", idx[1] - idx[0], 21);
                chk("t6_gap2", idx[2] - idx[1], 9);
            end
            chk("t6_up", {31'd0, Up}, 0);
            BtnDn = 1'b0;
            run(20, cnt, first);
        end
`endif

        // randomized button activity, model-checked every cycle
        for (seg = 0; seg < 500; seg++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin BtnUp = 1'b1; BtnDn = 1'b0; len = $urandom_range(5, 40); end
                3, 4, 5: begin BtnUp = 1'b0; BtnDn = 1'b1; len = $urandom_range(5, 40); end
                6:       begin BtnUp = 1'b1; BtnDn = 1'b1; len = $urandom_range(2, 20); end
                7:       begin BtnUp = $urandom_range(0, 1); BtnDn = $urandom_range(0, 1); len = $urandom_range(1, 3); end
                default: begin BtnUp = 1'b0; BtnDn = 1'b0; len = $urandom_range(3, 25); end
            endcase
            if ($urandom_range(0, 39) == 0) begin
                Reset = 1'b1;
                run($urandom_range(1, 2), cnt, first);
                Reset = 1'b0;
            end
            run(len, cnt, first);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
